regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-write debug register file used in the single-cycle ARM core.
- Provides NREG x DATA_W storage, two combinational read ports, two synchronous write ports (ALU result plus load/store base writeback), and a debug read port.
- Optional same-cycle write-to-read bypass for later pipelined cores.
- The PC register is never stored; reads of it return the externally supplied PC+8 value, and writes to it are reported on a branch strobe.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, address width; NREG = 2**ADDR_W registers
PC_REG, 15, index of the PC alias register
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see pre-edge contents

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset (0 = reset asserted)
A1  in  ADDR_W  read port 1 address
A2  in  ADDR_W  read port 2 address
RD1  out  DATA_W  read port 1 data
RD2  out  DATA_W  read port 2 data
WE3  in  1  write enable, port 3 (ALU result)
A3  in  ADDR_W  write address, port 3
WD3  in  DATA_W  write data, port 3
WE4  in  1  write enable, port 4 (base writeback)
A4  in  ADDR_W  write address, port 4
WD4  in  DATA_W  write data, port 4
R15  in  DATA_W  current PC+8 value
PCWr  out  1  a write targeting PC_REG is requested this cycle
PCWrData  out  DATA_W  data of that PC write
DBtheReg  in  ADDR_W  debug read address
DBtheRegVal  out  DATA_W  debug read data
WrCount  out  16  count of committed register writes (debug)

Behaviour:
Storage and reset
- NREG-1 storage words; PC_REG has no storage.
- reset low: all storage and WrCount clear to 0 immediately (asynchronous) and stay 0 while reset is low; writes are ignored.
- Deassertion takes effect at the next rising clk edge.

Reads (combinational)
- Applies to RD1, RD2 and DBtheRegVal.
- Address == PC_REG: output R15, including during reset.
- Any other address: output the stored word.
- During reset, non-PC reads return 0.

Writes (on rising clk edge, reset high)
- WEn=1 and An != PC_REG: storage[An] <= WDn.
- Both ports enabled with A3 == A4: port 3 wins, port 4 is discarded, and it counts as one write.
- Distinct addresses: both written in the same edge.

Bypass
- Applies only when BYPASS=1 and reset is high.
- A non-PC read address matching an enabled write address in the same cycle returns that write data before the edge, using the port-3-over-port-4 priority.
- Applies to RD1, RD2 and DBtheRegVal.
- BYPASS=0: reads return old contents until after the edge.

PC write
- PCWr = reset & ((WE3 & A3==PC_REG) | (WE4 & A4==PC_REG)). Combinational.
- PCWrData = WD3 when port 3 targets PC_REG, else WD4, else 0.
- A PC write never alters storage or WrCount.

WrCount
- Increments at each edge by the number of distinct non-PC storage words written (0, 1 or 2).
- Wraps modulo 2^16.

Timing
- No other state. Write-to-read latency:
  - BYPASS=1: 0 cycles.
  - BYPASS=0: 1 edge.

Test Plan:
1. Reset low mid-run after writing R3=0x1234; assert reset between edges → RD1(A1=3)=0 immediately, WrCount=0; release, write R3=0xA5A5 → RD1=0xA5A5 after the edge.
2. WE3=1, A3=0, WD3=0xF; next cycle A3=1, WD3=0xF0; then WE3=0, A1=0, A2=1 → RD1=0x0000000F, RD2=0x000000F0, WrCount=2.
3. WE3=WE4=1, A3=A4=5, WD3=0x11, WD4=0x22 → R5=0x11 after the edge, WrCount +1. Repeat with A4=6 → R5=0x11, R6=0x22, WrCount +2.
4. R15=0x108, WE3=1, A3=15, WD3=0x200, A1=15 → RD1=0x108, PCWr=1, PCWrData=0x200, no storage change, WrCount unchanged.
5. BYPASS=1: WE3=1, A3=7, WD3=0xDEAD, A2=7 within the same cycle → RD2=0xDEAD before the edge. BYPASS=0 → RD2 shows the old value until the edge, then 0xDEAD.
6. DBtheReg sweep 0..15 after writing Rn=n*0x10 for n=0..14 → DBtheRegVal=n*0x10 for n<15, =R15 for n=15. Drive 65537 single writes → WrCount wraps to 1.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational reads, a debug read, and two writes per edge; the PC index aliases R15.
// Reads are zero-latency (optionally bypassed from same-cycle writes); writes and WrCount commit on the rising edge.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PC_REG = 15,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE4,
    input  logic [ADDR_W-1:0] A4,
    input  logic [DATA_W-1:0] WD4,
    input  logic [DATA_W-1:0] R15,
    output logic              PCWr,
    output logic [DATA_W-1:0] PCWrData,
    input  logic [ADDR_W-1:0] DBtheReg,
    output logic [DATA_W-1:0] DBtheRegVal,
    output logic [15:0]       WrCount
);
    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

    logic [DATA_W-1:0] mem [NREG];
    logic              wr3;
    logic              wr4;
    logic              pc3;
    logic              pc4;

    // Port 4 is dropped when port 3 already owns the same word, so the pair counts once.
    assign wr3 = reset && WE3 && (A3 != PC_ADDR);
    assign wr4 = reset && WE4 && (A4 != PC_ADDR) && !(wr3 && (A3 == A4));
    assign pc3 = reset && WE3 && (A3 == PC_ADDR);
    assign pc4 = reset && WE4 && (A4 == PC_ADDR);

    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
        if (a == PC_ADDR)
            return R15;
        if ((BYPASS != 0) && wr3 && (A3 == a))
            return WD3;
        if ((BYPASS != 0) && wr4 && (A4 == a))
            return WD4;
        return mem[a];
    endfunction

    always_comb begin
        RD1         = read_word(A1);
        RD2         = read_word(A2);
        DBtheRegVal = read_word(DBtheReg);
    end

    always_comb begin
        PCWr     = pc3 || pc4;
        PCWrData = '0;
        if (pc3)
            PCWrData = WD3;
        else if (pc4)
            PCWrData = WD4;
    end

    // The PC slot is never written, so it stays at its reset value and is optimised away.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
        end else begin
            if (wr3)
                mem[A3] <= WD3;
            if (wr4)
                mem[A4] <= WD4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            WrCount <= '0;
        else
            WrCount <= WrCount + 16'(wr3) + 16'(wr4);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share all inputs.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  A1, A2, A3, A4, DBtheReg;
    logic        WE3, WE4;
    logic [31:0] WD3, WD4, R15;

    logic [31:0] b_RD1, b_RD2, b_PCWrData, b_DBtheRegVal;
    logic [31:0] n_RD1, n_RD2, n_PCWrData, n_DBtheRegVal;
    logic        b_PCWr, n_PCWr;
    logic [15:0] b_WrCount, n_WrCount;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(4), .PC_REG(15), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .RD1(b_RD1), .RD2(b_RD2),
        .WE3(WE3), .A3(A3), .WD3(WD3), .WE4(WE4), .A4(A4), .WD4(WD4), .R15(R15),
        .PCWr(b_PCWr), .PCWrData(b_PCWrData), .DBtheReg(DBtheReg),
        .DBtheRegVal(b_DBtheRegVal), .WrCount(b_WrCount)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(4), .PC_REG(15), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .RD1(n_RD1), .RD2(n_RD2),
        .WE3(WE3), .A3(A3), .WD3(WD3), .WE4(WE4), .A4(A4), .WD4(WD4), .R15(R15),
        .PCWr(n_PCWr), .PCWrData(n_PCWrData), .DBtheReg(DBtheReg),
        .DBtheRegVal(n_DBtheRegVal), .WrCount(n_WrCount)
    );

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        A1 = '0; A2 = '0; A3 = '0; A4 = '0; DBtheReg = '0;
        WE3 = 1'b0; WE4 = 1'b0; WD3 = '0; WD4 = '0;
        R15 = 32'h108;
        #2;

        // Reset state: storage reads 0, PC alias still visible, PC write suppressed.
        A1 = 4'd3; A2 = 4'd15; WE3 = 1'b1; A3 = 4'd15; WD3 = 32'h55;
        settle();
        sb_push("rst_rd1", 32'h0);       sb_check(b_RD1);
        sb_push("rst_rd2_pc", 32'h108);  sb_check(b_RD2);
        sb_push("rst_wrcount", 32'h0);   sb_check(32'(b_WrCount));
        sb_push("rst_pcwr", 32'h0);      sb_check(32'(b_PCWr));
        WE3 = 1'b0;
        tick();
        reset = 1'b1;

        // 1: reset mid-run clears storage immediately, writes resume after release.
        WE3 = 1'b1; A3 = 4'd3; WD3 = 32'h1234;
        tick();
        WE3 = 1'b0; A1 = 4'd3;
        settle();
        sb_push("t1_rd1", 32'h1234);     sb_check(n_RD1);
        reset = 1'b0;
        settle();
        sb_push("t1_rst_rd1", 32'h0);    sb_check(b_RD1);
        sb_push("t1_rst_cnt", 32'h0);    sb_check(32'(n_WrCount));
        reset = 1'b1;
        WE3 = 1'b1; A3 = 4'd3; WD3 = 32'hA5A5;
        settle();
        sb_push("t1_byp_rd1", 32'hA5A5); sb_check(b_RD1);
        sb_push("t1_nob_old", 32'h0);    sb_check(n_RD1);
        tick();
        WE3 = 1'b0;
        settle();
        sb_push("t1_nob_new", 32'hA5A5); sb_check(n_RD1);
        sb_push("t1_cnt", 32'h1);        sb_check(32'(b_WrCount));

        // 2: back-to-back single writes.
        pulse_reset();
        WE3 = 1'b1; A3 = 4'd0; WD3 = 32'hF;
        tick();
        A3 = 4'd1; WD3 = 32'hF0;
        tick();
        WE3 = 1'b0; A1 = 4'd0; A2 = 4'd1;
        settle();
        sb_push("t2_rd1", 32'hF);        sb_check(n_RD1);
        sb_push("t2_rd2", 32'hF0);       sb_check(n_RD2);
        sb_push("t2_cnt", 32'h2);        sb_check(32'(n_WrCount));

        // 3: dual write, same address then distinct addresses.
        WE3 = 1'b1; WE4 = 1'b1; A3 = 4'd5; A4 = 4'd5; WD3 = 32'h11; WD4 = 32'h22; A1 = 4'd5;
        settle();
        sb_push("t3_byp_prio", 32'h11);  sb_check(b_RD1);
        tick();
        WE3 = 1'b0; WE4 = 1'b0;
        settle();
        sb_push("t3_r5", 32'h11);        sb_check(n_RD1);
        sb_push("t3_cnt_same", 32'h3);   sb_check(32'(n_WrCount));
        WE3 = 1'b1; WE4 = 1'b1; A3 = 4'd5; A4 = 4'd6; WD3 = 32'h11; WD4 = 32'h22; A2 = 4'd6;
        settle();
        sb_push("t3_byp_p4", 32'h22);    sb_check(b_RD2);
        tick();
        WE3 = 1'b0; WE4 = 1'b0;
        settle();
        sb_push("t3_r5_b", 32'h11);      sb_check(n_RD1);
        sb_push("t3_r6", 32'h22);        sb_check(n_RD2);
        sb_push("t3_cnt_dist", 32'h5);   sb_check(32'(n_WrCount));

        // 4: PC writes are reported, not stored or counted.
        WE3 = 1'b1; A3 = 4'd15; WD3 = 32'h200; WE4 = 1'b1; A4 = 4'd15; WD4 = 32'h300; A1 = 4'd15;
        settle();
        sb_push("t4_rd1_pc", 32'h108);   sb_check(b_RD1);
        sb_push("t4_pcwr", 32'h1);       sb_check(32'(n_PCWr));
        sb_push("t4_pcdata_p3", 32'h200); sb_check(b_PCWrData);
        WE3 = 1'b0;
        settle();
        sb_push("t4_pcdata_p4", 32'h300); sb_check(n_PCWrData);
        tick();
        WE4 = 1'b0; A1 = 4'd5;
        settle();
        sb_push("t4_pcwr_off", 32'h0);   sb_check(32'(b_PCWr));
        sb_push("t4_cnt", 32'h5);        sb_check(32'(n_WrCount));
        sb_push("t4_r5_kept", 32'h11);   sb_check(n_RD1);

        // 5: same-cycle bypass vs. registered read.
        WE3 = 1'b1; A3 = 4'd7; WD3 = 32'h1111;
        tick();
        WD3 = 32'hDEAD; A2 = 4'd7;
        settle();
        sb_push("t5_byp_rd2", 32'hDEAD); sb_check(b_RD2);
        sb_push("t5_nob_old", 32'h1111); sb_check(n_RD2);
        tick();
        WE3 = 1'b0;
        settle();
        sb_push("t5_nob_new", 32'hDEAD); sb_check(n_RD2);
        WE4 = 1'b1; A4 = 4'd8; WD4 = 32'hBEEF; DBtheReg = 4'd8;
        settle();
        sb_push("t5_byp_dbg", 32'hBEEF); sb_check(b_DBtheRegVal);
        sb_push("t5_nob_dbg", 32'h0);    sb_check(n_DBtheRegVal);
        WE4 = 1'b0;

        // 6: debug sweep, then WrCount wrap.
        pulse_reset();
        for (int n = 0; n < 15; n++) begin
            WE3 = 1'b1; A3 = 4'(n); WD3 = 32'(n * 16);
            tick();
        end
        WE3 = 1'b0;
        for (int n = 0; n < 16; n++) begin
            DBtheReg = 4'(n);
            settle();
            sb_push($sformatf("t6_dbg_b%0d", n), (n == 15) ? R15 : 32'(n * 16));
            sb_check(b_DBtheRegVal);
            sb_push($sformatf("t6_dbg_n%0d", n), (n == 15) ? R15 : 32'(n * 16));
            sb_check(n_DBtheRegVal);
        end
        sb_push("t6_cnt15", 32'd15);     sb_check(32'(b_WrCount));
        pulse_reset();
        WE3 = 1'b1; A3 = 4'd2; WD3 = 32'h1;
        repeat (65537) tick();
        WE3 = 1'b0;
        settle();
        sb_push("t6_wrap_b", 32'h1);     sb_check(32'(b_WrCount));
        sb_push("t6_wrap_n", 32'h1);     sb_check(32'(n_WrCount));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
